timer_responder: RTL and testbench
==================================

Name: timer_responder

Overview:
- Memory-mapped countdown timer that responds to the CPU's load/store data bus.
- The CPU datapath is the bus initiator; this block is the responder at the other end. It decodes its address window, returns read data, and accepts word writes.
- It raises an interrupt request toward the CPU.
- Sits beside data memory under the top-level CPU wrapper.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base of the 16-byte register window; low 4 bits must be 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the CPU; low 2 bits ignored.
- we  in  1  write strobe; the write commits at the rising edge when the window is selected.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr and current registers.
- irq  out  1  interrupt request to the CPU.

Behaviour:
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]). Writes with sel=0 are ignored. rdata=0 when sel=0.
- Register map, indexed by addr[3:2]:
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 PRESET: 32-bit, read/write.
  - 2 COUNT: 32-bit, read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and rdata depends only on addr.
- irq = irq_flag & CTRL.IM, combinational.
- FSM, evaluated each rising edge:
  - IDLE: EN=1 → LOAD; else stay.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT: EN=0 → IDLE, COUNT holds. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1 → INT.
  - INT, MODE=0: EN<=0 → IDLE; irq_flag stays 1.
  - INT, MODE=1: irq_flag<=0 → LOAD (auto-reload); irq_flag is high exactly 1 cycle.
  - MODE=2 and MODE=3 behave as MODE=0.
- irq_flag clear: in MODE=0 it clears on any selected CPU write to CTRL or PRESET.
- Latency: with PRESET=N≥1, EN is written at edge E0. LOAD occurs at E1, INT is entered at E(N+1), and irq is high after E(N+1). PRESET=0 behaves as PRESET=1.
- Simultaneous events:
  - CPU write to CTRL in the same edge that INT clears EN: the CPU write wins.
  - CPU write to PRESET during CNT: affects only the next LOAD.
  - CPU write of EN=0 during LOAD: COUNT still loads, then the next edge goes IDLE.
- COUNT never wraps below 0. PRESET=32'hFFFF_FFFF counts normally.
- Reset mid-count: all state is zeroed at that edge, and irq drops the following cycle.

Optional Feature:
- Macro: TIMER_BYTEEN_EN.
- Defined: adds port be (in, 4) of byte enables. A selected write updates only the bytes of CTRL/PRESET whose be bit is 1. be=0 is not a write and does not clear irq_flag.
- Undefined: no be port; every selected write is a full 32-bit write.

Test Plan:
- Reset: assert reset 2 cycles, then read each of offsets 0/4/8/C → rdata=0 and irq=0.
- Mode 0: write PRESET=3, then CTRL=0x9 at E0. Required response:
  - COUNT reads 3, 2, 1, 0 after E1..E4.
  - irq=1 after E4 and held.
  - CTRL reads 0x8 after E5.
  - A write of CTRL=0x8 drops irq.
- Mode 1: PRESET=2, CTRL=0xB. Required response:
  - irq pulses 1 cycle, then the timer reloads to 2.
  - Pulses are spaced 4 cycles apart (LOAD, CNT, CNT, INT) over 3 periods.
- Abort: PRESET=10, start, then write CTRL=0 while COUNT=6 → state goes IDLE, COUNT holds 6, no irq.
- Mask and ignored writes:
  - CTRL=0x1 with PRESET=1 → COUNT reaches 0 and irq stays 0.
  - A write to offset 8 or to an address outside the window leaves all registers unchanged.
- Byte enables (TIMER_BYTEEN_EN): PRESET=0x11223344, then write be=4'b0010 with wdata=0xAABBCCDD → PRESET reads 0x1122CC44.

Source files
------------

// File: rtl/timer_responder.sv
// Memory-mapped countdown timer responder: CTRL/PRESET/COUNT window with maskable IRQ.
// Optional byte-enable write port when TIMER_BYTEEN_EN is defined.
module timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
`ifdef TIMER_BYTEEN_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  state_t      state, state_d;
  logic [3:0]  ctrl_q, ctrl_w, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag, irq_flag_d;
  logic        sel, wr, wr_ctrl, wr_preset;
  logic [31:0] wmask;
  logic        en;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);

`ifdef TIMER_BYTEEN_EN
  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr    = sel & we & (|be);
`else
  assign wmask = '1;
  assign wr    = sel & we;
`endif

  assign wr_ctrl   = wr & (addr[3:2] == 2'd0);
  assign wr_preset = wr & (addr[3:2] == 2'd1);

  assign irq = irq_flag & ctrl_q[3];

  // The FSM sees the CTRL value being written this edge, so an EN write
  // takes effect immediately (start goes straight to LOAD, abort holds COUNT).
  always_comb begin
    ctrl_w = ctrl_q;
    if (wr_ctrl)
      ctrl_w = (ctrl_q & ~wmask[3:0]) | (wdata[3:0] & wmask[3:0]);
  end

  assign en = ctrl_w[0];

  always_comb begin
    state_d    = state;
    ctrl_d     = ctrl_w;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag;

    if (wr_preset)
      preset_d = (preset_q & ~wmask) | (wdata & wmask);
    if (wr_ctrl || wr_preset)
      irq_flag_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (en)
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          // A simultaneous CPU write of CTRL byte 0 overrides the auto-clear of EN.
          if (!(wr_ctrl && wmask[0]))
            ctrl_d[0] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_flag <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// Directed self-checking bench for timer_responder (mode 0/1, abort, mask, ignored writes, reset).
// Byte-enable steps are included when TIMER_BYTEEN_EN is defined.
module tb_timer_responder;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSV    = 32'h0000_7F0C;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
`ifdef TIMER_BYTEEN_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        irq;

  int unsigned total;
  int unsigned failed;

  timer_responder #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
`ifdef TIMER_BYTEEN_EN
    .be    (be),
`endif
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    we = 1'b1;
`ifdef TIMER_BYTEEN_EN
    be = 4'hF;
`endif
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    total = 0;
    failed = 0;
    reset = 1'b1;
    addr = '0;
    we = 1'b0;
    wdata = '0;
`ifdef TIMER_BYTEEN_EN
    be = 4'hF;
`endif

    // Reset
    tick(2);
    reset = 1'b0;
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_preset", A_PRESET, 32'h0);
    chk_rd("rst_count", A_COUNT, 32'h0);
    chk_rd("rst_rsv", A_RSV, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Mode 0, PRESET=3
    wr(A_PRESET, 32'd3);
    chk_rd("m0_preset", A_PRESET, 32'd3);
    wr(A_CTRL, 32'h9);
    tick(1);
    chk_rd("m0_cnt_e1", A_COUNT, 32'd3);
    tick(1);
    chk_rd("m0_cnt_e2", A_COUNT, 32'd2);
    tick(1);
    chk_rd("m0_cnt_e3", A_COUNT, 32'd1);
    chk_irq("m0_irq_e3", 1'b0);
    tick(1);
    chk_rd("m0_cnt_e4", A_COUNT, 32'd0);
    chk_irq("m0_irq_e4", 1'b1);
    tick(1);
    chk_irq("m0_irq_e5", 1'b1);
    chk_rd("m0_ctrl_e5", A_CTRL, 32'h8);
    tick(2);
    chk_irq("m0_irq_held", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("m0_irq_clr", 1'b0);
    chk_rd("m0_ctrl_after", A_CTRL, 32'h8);

    // Mode 1 auto-reload, PRESET=2: pulses after E3, E7, E11
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'hB);
    tick(2);
    chk_irq("m1_irq_pre", 1'b0);
    tick(1);
    for (int p = 0; p < 3; p++) begin
      chk_irq("m1_irq_high", 1'b1);
      tick(1);
      chk_irq("m1_irq_low", 1'b0);
      tick(1);
      chk_rd("m1_reload", A_COUNT, 32'd2);
      chk_irq("m1_irq_cnt", 1'b0);
      tick(2);
    end
    wr(A_CTRL, 32'h0);
    tick(3);

    // Abort at COUNT=6, PRESET=10
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    tick(5);
    chk_rd("ab_cnt6", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h8);
    chk_rd("ab_hold", A_COUNT, 32'd6);
    tick(3);
    chk_rd("ab_hold_late", A_COUNT, 32'd6);
    chk_irq("ab_irq", 1'b0);
    chk_rd("ab_ctrl", A_CTRL, 32'h8);

    // Masked interrupt, PRESET=1
    wr(A_PRESET, 32'd1);
    wr(A_CTRL, 32'h1);
    tick(2);
    chk_rd("mk_cnt0", A_COUNT, 32'd0);
    chk_irq("mk_irq", 1'b0);
    tick(1);
    chk_rd("mk_ctrl_en_clr", A_CTRL, 32'h0);

    // Ignored writes: COUNT, reserved, outside window
    wr(A_COUNT, 32'h55);
    chk_rd("ig_count", A_COUNT, 32'd0);
    wr(A_RSV, 32'hFFFF_FFFF);
    chk_rd("ig_rsv", A_RSV, 32'h0);
    wr(32'h0000_7F10, 32'h9);
    wr(32'h0000_0F04, 32'h1234_5678);
    tick(2);
    chk_rd("ig_ctrl", A_CTRL, 32'h0);
    chk_rd("ig_preset", A_PRESET, 32'd1);
    chk_rd("ig_count2", A_COUNT, 32'd0);
    chk_rd("ig_outside_rd", 32'h0000_7F14, 32'h0);
    wr(A_CTRL, 32'h8);
    chk_irq("ig_irq_clr", 1'b0);

    // PRESET=0 behaves as PRESET=1
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    tick(1);
    chk_irq("p0_irq_e1", 1'b0);
    tick(1);
    chk_irq("p0_irq_e2", 1'b1);
    wr(A_CTRL, 32'h8);
    chk_irq("p0_irq_clr", 1'b0);

`ifdef TIMER_BYTEEN_EN
    wr(A_PRESET, 32'h1122_3344);
    addr = A_PRESET;
    wdata = 32'hAABB_CCDD;
    we = 1'b1;
    be = 4'b0010;
    tick(1);
    we = 1'b0;
    be = 4'hF;
    chk_rd("be_merge", A_PRESET, 32'h1122_CC44);
`endif

    // Reset mid-count
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_rd("rm_count", A_COUNT, 32'h0);
    chk_rd("rm_ctrl", A_CTRL, 32'h0);
    chk_rd("rm_preset", A_PRESET, 32'h0);
    tick(3);
    chk_rd("rm_count_idle", A_COUNT, 32'h0);
    chk_irq("rm_irq", 1'b0);

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
